// File: rtl/sd_ctrl_regfile_if.sv
// sd_ctrl_regfile_if: AXI4-Lite channel bundle between the PS interconnect and the SD control register file.
interface sd_ctrl_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/sd_ctrl_regfile.sv
// sd_ctrl_regfile: AXI4-Lite register file with byte strobes, write pulses and a user write port.
// SD_CTRL_REGFILE_RANGE_ERR_EN: out-of-range AXI index gets SLVERR instead of wrapping.
module sd_ctrl_regfile #(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  NUM_REGS   = 8,
   parameter int                  ADDR_WIDTH = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   sd_ctrl_regfile_if.slave               s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse,
   input  logic                           usr_wr_en,
   input  logic [$clog2(NUM_REGS)-1:0]    usr_wr_idx,
   input  logic [DATA_WIDTH-1:0]          usr_wr_data
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IW    = $clog2(NUM_REGS);
`ifdef SD_CTRL_REGFILE_RANGE_ERR_EN
   localparam bit RANGE_ERR = 1'b1;
   localparam int SIW       = ADDR_WIDTH - LSB;
`else
   localparam bit RANGE_ERR = 1'b0;
   localparam int SIW       = IW;
`endif
   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;
   w_state_e                    w_state_q, w_state_d;
   r_state_e                    r_state_q, r_state_d;
   logic                        aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [SIW-1:0]              aw_idx_q, aw_idx_d, ar_idx;
   logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
   logic [BYTES-1:0]            wstrb_q, wstrb_d;
   logic                        awready_q, awready_d, wready_q, wready_d;
   logic                        bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
   logic [1:0]                  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]       rdata_q, rdata_d, rd_word;
   logic [NUM_REGS-1:0]         pulse_q, pulse_d;
   logic [NUM_REGS*DATA_WIDTH-1:0] reg_d;
   logic                        commit;
   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;
   assign reg_wr_pulse  = pulse_q;
   assign ar_idx        = s_axi.araddr[LSB +: SIW];
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_idx_d  = aw_idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      reg_d     = reg_q;
      commit    = 1'b0;
      if (w_state_q == W_IDLE) begin
         if (s_axi.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.awaddr[LSB +: SIW];
         end
         if (s_axi.wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
         end
         if (aw_held_q && w_held_q) begin
            commit    = 1'b1;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (RANGE_ERR && int'(aw_idx_q) >= NUM_REGS) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
         end
      end else if (s_axi.bready) begin
         bvalid_d  = 1'b0;
         w_state_d = W_IDLE;
      end
      awready_d = (w_state_d == W_IDLE) && !aw_held_d;
      wready_d  = (w_state_d == W_IDLE) && !w_held_d;
      // an index that never matches a register (out of range) simply writes nothing
      for (int i = 0; i < NUM_REGS; i++) begin
         if (commit && int'(aw_idx_q) == i && !RO_MASK[i]) begin
            pulse_d[i] = 1'b1;
            for (int b = 0; b < BYTES; b++)
               if (wstrb_q[b]) reg_d[i*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
         end
         if (usr_wr_en && int'(usr_wr_idx) == i) reg_d[i*DATA_WIDTH +: DATA_WIDTH] = usr_wr_data;
      end
   end
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_word   = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(ar_idx) == i) rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      if (r_state_q == R_IDLE) begin
         if (s_axi.arvalid && arready_q) begin
            rdata_d   = rd_word;
            rresp_d   = (RANGE_ERR && int'(ar_idx) >= NUM_REGS) ? 2'b10 : 2'b00;
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
         end
      end else if (s_axi.rready) begin
         rvalid_d  = 1'b0;
         r_state_d = R_IDLE;
      end
      arready_d = r_state_d == R_IDLE;
   end
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         pulse_q   <= '0;
         reg_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_idx_q  <= aw_idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         pulse_q   <= pulse_d;
         reg_q     <= reg_d;
      end
   end
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end
endmodule

// File: tb/tb_sd_ctrl_regfile.sv
// tb_sd_ctrl_regfile: vector table, corner sequences and random traffic against a word-array model.
module tb_sd_ctrl_regfile;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 8;
   localparam int LIM = 50;
   localparam logic [NR-1:0] RO = 8'h02;
`ifdef SD_CTRL_REGFILE_RANGE_ERR_EN
   localparam bit RERR = 1'b1;
`else
   localparam bit RERR = 1'b0;
`endif
   typedef struct {
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic [3:0]    strb;
      logic [1:0]    bresp;
      logic [AW-1:0] raddr;
      logic [DW-1:0] rdata;
      logic [1:0]    rresp;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   sd_ctrl_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_axi();
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;
   logic             usr_wr_en;
   logic [2:0]       usr_wr_idx;
   logic [DW-1:0]    usr_wr_data;
   sd_ctrl_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO)) dut (
      .ACLK(clk), .ARESET(rst), .s_axi(s_axi), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse),
      .usr_wr_en(usr_wr_en), .usr_wr_idx(usr_wr_idx), .usr_wr_data(usr_wr_data)
   );
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] m [NR];
   int exp_pulse [NR];
   int pcnt [NR];
   vec_t vec [9];
   always @(negedge clk)
      for (int i = 0; i < NR; i++) if (reg_wr_pulse[i]) pcnt[i]++;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic int model_idx(input logic [AW-1:0] a);
      int k = int'(a) / (DW / 8);
      if (RERR) return (k < NR) ? k : -1;
      return k % NR;
   endfunction
   function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
      return (RERR && int'(a) / (DW / 8) >= NR) ? 2'b10 : 2'b00;
   endfunction
   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      int k = model_idx(a);
      if (k < 0) return '0;
      return m[k];
   endfunction
   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      int k = model_idx(a);
      if (k >= 0 && !RO[k]) begin
         for (int b = 0; b < 4; b++) if (s[b]) m[k][8*b +: 8] = d[8*b +: 8];
         exp_pulse[k]++;
      end
   endtask
   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      logic a_hs, w_hs;
      logic a_done = 1'b0;
      logic w_done = 1'b0;
      s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
      while (!(a_done && w_done) && n < LIM) begin
         a_hs = s_axi.awvalid && s_axi.awready;
         w_hs = s_axi.wvalid && s_axi.wready;
         @(negedge clk); n++;
         if (a_hs) begin a_done = 1'b1; s_axi.awvalid = 1'b0; end
         if (w_hs) begin w_done = 1'b1; s_axi.wvalid = 1'b0; end
      end
      while (!s_axi.bvalid && n < LIM) begin @(negedge clk); n++; end
      chk("wr_timeout", n >= LIM, 0);
      resp = s_axi.bresp;
      s_axi.bready = 1'b1;
      @(negedge clk);
      s_axi.bready = 1'b0; s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      model_write(a, d, s);
   endtask
   task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
      int n = 0;
      logic hs;
      logic done = 1'b0;
      s_axi.araddr = a; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
      while (!done && n < LIM) begin
         hs = s_axi.arvalid && s_axi.arready;
         @(negedge clk); n++;
         if (hs) begin done = 1'b1; s_axi.arvalid = 1'b0; end
      end
      chk("rd_latency", s_axi.rvalid, 1);
      while (!s_axi.rvalid && n < LIM) begin @(negedge clk); n++; end
      chk("rd_timeout", n >= LIM, 0);
      d = s_axi.rdata; resp = s_axi.rresp;
      s_axi.rready = 1'b1;
      @(negedge clk);
      s_axi.rready = 1'b0; s_axi.arvalid = 1'b0;
   endtask
   task automatic usr_write(input logic [2:0] idx, input logic [DW-1:0] d);
      usr_wr_en = 1'b1; usr_wr_idx = idx; usr_wr_data = d;
      @(negedge clk);
      usr_wr_en = 1'b0;
      m[idx] = d;
   endtask
   initial begin
      logic [1:0] resp, rr;
      logic [DW-1:0] rd, ed;
      logic [AW-1:0] a;
      logic [NR*DW-1:0] flat;
      int n;
      vec[0] = '{8'h00, 32'h1, 4'hF, 2'b00, 8'h00, 32'h1, 2'b00};
      vec[1] = '{8'h04, 32'h2, 4'hF, 2'b00, 8'h04, 32'h0, 2'b00};
      vec[2] = '{8'h08, 32'h3, 4'hF, 2'b00, 8'h08, 32'h3, 2'b00};
      vec[3] = '{8'h0C, 32'h4, 4'hF, 2'b00, 8'h0C, 32'h4, 2'b00};
      vec[4] = '{8'h08, 32'hAABBCCDD, 4'hF, 2'b00, 8'h08, 32'hAABBCCDD, 2'b00};
      vec[5] = '{8'h08, 32'h11223344, 4'h5, 2'b00, 8'h08, 32'hAA22CC44, 2'b00};
      vec[6] = '{8'h1E, 32'hFFFFFFFF, 4'hC, 2'b00, 8'h1C, 32'hFFFF0000, 2'b00};
      vec[7] = '{8'h60, 32'h77, 4'hF, RERR ? 2'b10 : 2'b00, 8'h40, RERR ? 32'h0 : 32'h77, RERR ? 2'b10 : 2'b00};
      vec[8] = '{8'h10, 32'hCAFEF00D, 4'hF, 2'b00, 8'h00, RERR ? 32'h1 : 32'h77, 2'b00};
      for (int i = 0; i < NR; i++) begin m[i] = '0; exp_pulse[i] = 0; end
      s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 0; s_axi.bready = 0; s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 0;
      s_axi.rready = 0; usr_wr_en = 0; usr_wr_idx = '0; usr_wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
      chk("rst_valid", {s_axi.bvalid, s_axi.rvalid, s_axi.bresp, s_axi.rresp}, 6'b0);
      chk("rst_rdata", s_axi.rdata, 0);
      chk("rst_regs", reg_q, 0);
      chk("rst_pulse", reg_wr_pulse, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
      for (int i = 0; i < 9; i++) begin
         axi_write(vec[i].waddr, vec[i].wdata, vec[i].strb, resp);
         chk($sformatf("vec%0d_bresp", i), resp, vec[i].bresp);
         axi_read(vec[i].raddr, rd, rr);
         chk($sformatf("vec%0d_rdata", i), rd, vec[i].rdata);
         chk($sformatf("vec%0d_rresp", i), rr, vec[i].rresp);
      end
      for (int i = 0; i < NR; i++) chk($sformatf("tbl_pulse%0d", i), pcnt[i], exp_pulse[i]);
      s_axi.wdata = 32'h12345678; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
      @(negedge clk);
      s_axi.wvalid = 1'b0;
      chk("ord_w_taken", s_axi.wready, 0);
      repeat (2) begin
         @(negedge clk);
         chk("ord_wait_aw", {s_axi.awready, s_axi.wready, s_axi.bvalid}, 3'b100);
      end
      s_axi.awaddr = 8'h0C; s_axi.awvalid = 1'b1;
      @(negedge clk);
      s_axi.awvalid = 1'b0;
      chk("ord_aw_taken", s_axi.awready, 0);
      n = 0;
      while (!s_axi.bvalid && n < LIM) begin @(negedge clk); n++; end
      repeat (5) begin
         chk("ord_bhold", {s_axi.bvalid, s_axi.awready, s_axi.wready}, 3'b100);
         @(negedge clk);
      end
      s_axi.bready = 1'b1;
      @(negedge clk);
      s_axi.bready = 1'b0;
      chk("ord_bdone", {s_axi.bvalid, s_axi.awready, s_axi.wready}, 3'b011);
      model_write(8'h0C, 32'h12345678, 4'hF);
      axi_read(8'h0C, rd, rr);
      chk("ord_rdata", rd, 32'h12345678);
      usr_write(3'd1, 32'h55);
      chk("usr_ro_write", reg_q[63:32], 32'h55);
      s_axi.awaddr = 8'h00; s_axi.wdata = 32'hAAAA0000; s_axi.wstrb = 4'hF;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
      @(negedge clk);
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      usr_wr_en = 1'b1; usr_wr_idx = 3'd0; usr_wr_data = 32'h99;
      @(negedge clk);
      usr_wr_en = 1'b0;
      chk("coll_bvalid", s_axi.bvalid, 1);
      chk("coll_pulse", reg_wr_pulse, 8'h01);
      chk("coll_user_wins", reg_q[31:0], 32'h99);
      @(negedge clk);
      s_axi.bready = 1'b0;
      chk("coll_bdone", s_axi.bvalid, 0);
      m[0] = 32'h99; exp_pulse[0]++;
      for (int it = 0; it < 60; it++) begin
         a = 8'($urandom_range(0, 127));
         case ($urandom_range(0, 2))
            0: begin
               ed = $urandom;
               rr = model_resp(a);
               axi_write(a, ed, 4'($urandom_range(0, 15)), resp);
               chk("rnd_bresp", resp, rr);
            end
            1: begin
               ed = model_read(a);
               axi_read(a, rd, rr);
               chk("rnd_rdata", rd, ed);
               chk("rnd_rresp", rr, model_resp(a));
            end
            default: begin
               n = $urandom_range(0, NR - 1);
               ed = $urandom;
               usr_write(3'(n), ed);
               chk("rnd_usr", reg_q[n*DW +: DW], ed);
            end
         endcase
      end
      for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m[i];
      chk("rnd_regq", reg_q, flat);
      s_axi.awaddr = 8'h10; s_axi.wdata = 32'h5A5A5A5A; s_axi.wstrb = 4'hF;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
      s_axi.araddr = 8'h10; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
      @(negedge clk);
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
      n = 0;
      while (!(s_axi.bvalid && s_axi.rvalid) && n < LIM) begin @(negedge clk); n++; end
      chk("rstmid_pre", {s_axi.bvalid, s_axi.rvalid}, 2'b11);
      model_write(8'h10, 32'h5A5A5A5A, 4'hF);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_valid", {s_axi.bvalid, s_axi.rvalid, s_axi.awready, s_axi.wready, s_axi.arready}, 5'b0);
      chk("rstmid_regs", reg_q, 0);
      chk("rstmid_rdata", s_axi.rdata, 0);
      rst = 1'b0;
      for (int i = 0; i < NR; i++) m[i] = '0;
      @(negedge clk);
      chk("rstmid_ready", {s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid}, 5'b11100);
      axi_write(8'h14, 32'h0BADF00D, 4'hF, resp);
      chk("after_rst_bresp", resp, 2'b00);
      axi_read(8'h14, rd, rr);
      chk("after_rst_rdata", rd, 32'h0BADF00D);
      axi_read(8'h04, rd, rr);
      chk("after_rst_ro", rd, 32'h0);
      for (int i = 0; i < NR; i++) chk($sformatf("final_pulse%0d", i), pcnt[i], exp_pulse[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
